// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake bundle for muldiv_unit
// master drives operands, op select, valid_in and ready_in; slave returns ready_out, result and flags
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             signed_operation_in;
  logic [1:0]       operation_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] result_out;
  logic             valid_out;
  logic             ready_in;
  logic             zero_out;
  logic             overflow_out;
  logic             div_by_zero_out;
  modport master (
    output a_in, b_in, signed_operation_in, operation_in, valid_in, ready_in,
    input  ready_out, result_out, valid_out, zero_out, overflow_out, div_by_zero_out
  );
  modport slave (
    input  a_in, b_in, signed_operation_in, operation_in, valid_in, ready_in,
    output ready_out, result_out, valid_out, zero_out, overflow_out, div_by_zero_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle multiply (MUL/MULH) and divide (DIV/REM) unit
// clk_in/rst_in: clock and synchronous active-high reset
// bus (slave): operands a_in/b_in, signed_operation_in, operation_in, valid_in/ready_out request
//   handshake, result_out/valid_out/ready_in result handshake, zero/overflow/div_by_zero flags
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk_in,
  input logic         rst_in,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_nx, prod;
  logic [WIDTH-1:0] m, res, res_nx, mag_a, mag_b, quo, rem, hi, lo;
  logic [WIDTH:0] sum, s;
  logic [1:0] op;
  logic sgn, neg_q, neg_r, ov, ov_nx, dz, dz_nx;
  logic accept, is_div, fast_dz, fast_ov, last, ge;
  assign accept  = state == IDLE && bus.valid_in;
  assign is_div  = bus.operation_in[1];
  assign mag_a   = bus.signed_operation_in && bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign mag_b   = bus.signed_operation_in && bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  assign fast_dz = is_div && bus.b_in == '0;
  assign fast_ov = is_div && bus.signed_operation_in && bus.a_in == MIN && bus.b_in == '1;
  assign last    = cnt == CW'(WIDTH - 1);
  // p holds {high, low} of the product (shift-add) or {remainder, dividend/quotient} (restoring)
  assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
  assign s   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign ge  = s >= {1'b0, m};
  // a successful trial subtraction always leaves a value below m, so WIDTH bits suffice
  assign p_nx = op[1] ? {(ge ? s[WIDTH-1:0] - m : s[WIDTH-1:0]), p[WIDTH-2:0], ge}
              : p[0]  ? {sum, p[WIDTH-1:1]}
              :         {1'b0, p[2*WIDTH-1:WIDTH], p[WIDTH-1:1]};
  // magnitudes are processed unsigned; signs are reapplied to the finished result
  assign prod = neg_q ? -p_nx : p_nx;
  assign hi   = prod[2*WIDTH-1:WIDTH];
  assign lo   = prod[WIDTH-1:0];
  assign quo  = neg_q ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0];
  assign rem  = neg_r ? -p_nx[2*WIDTH-1:WIDTH] : p_nx[2*WIDTH-1:WIDTH];
  always_comb begin
    state_nx = state;
    res_nx   = res;
    ov_nx    = ov;
    dz_nx    = dz;
    if (accept) begin
      state_nx = fast_dz || fast_ov ? DONE : CALC;
      res_nx   = fast_dz ? (bus.operation_in[0] ? bus.a_in : '1) : (bus.operation_in[0] ? '0 : MIN);
      ov_nx    = fast_ov && !bus.operation_in[0];
      dz_nx    = fast_dz;
    end else if (state == CALC && last) begin
      state_nx = DONE;
      res_nx   = op == 2'b00 ? lo : op == 2'b01 ? hi : op == 2'b10 ? quo : rem;
      ov_nx    = op == 2'b00 && (sgn ? hi != {WIDTH{lo[WIDTH-1]}} : hi != '0);
      dz_nx    = 1'b0;
    end else if (state == DONE && bus.ready_in) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      ov    <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= state == CALC ? cnt + 1'b1 : '0;
      res   <= res_nx;
      ov    <= ov_nx;
      dz    <= dz_nx;
      if (accept) begin
        op    <= bus.operation_in;
        sgn   <= bus.signed_operation_in;
        neg_q <= bus.signed_operation_in && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
        neg_r <= bus.signed_operation_in && bus.a_in[WIDTH-1];
        m     <= is_div ? mag_b : mag_a;
        p     <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
      end else if (state == CALC) begin
        p <= p_nx;
      end
    end
  end
  assign bus.ready_out       = state == IDLE;
  assign bus.valid_out       = state == DONE;
  assign bus.result_out      = res;
  assign bus.zero_out        = bus.valid_out && res == '0;
  assign bus.overflow_out    = bus.valid_out && ov;
  assign bus.div_by_zero_out = bus.valid_out && dz;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH = 32
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [1:0] op, output int lat);
    bus.a_in = a;
    bus.b_in = b;
    bus.signed_operation_in = s;
    bus.operation_in = op;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    bus.signed_operation_in = ~s;
    bus.operation_in = ~op;
    lat = 1;
    while (!bus.valid_out && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic consume(input string tag);
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    chk({tag, "/ready_after"}, 32'(bus.ready_out), 32'd1);
    chk({tag, "/flags_after"}, {28'd0, bus.valid_out, bus.zero_out, bus.overflow_out, bus.div_by_zero_out}, 32'd0);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [1:0] op, input logic [31:0] er, input int el,
                     input logic z, input logic ov, input logic dz);
    int lat;
    chk({tag, "/ready_before"}, 32'(bus.ready_out), 32'd1);
    issue(a, b, s, op, lat);
    chk({tag, "/latency"}, 32'(lat), 32'(el));
    chk({tag, "/result"}, bus.result_out, er);
    chk({tag, "/zero"}, 32'(bus.zero_out), 32'(z));
    chk({tag, "/overflow"}, 32'(bus.overflow_out), 32'(ov));
    chk({tag, "/div_by_zero"}, 32'(bus.div_by_zero_out), 32'(dz));
    consume(tag);
  endtask
  initial begin
    int lat;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.signed_operation_in = 1'b0;
    bus.operation_in = 2'b00;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b0;
    tick();
    tick();
    chk("reset/ready", 32'(bus.ready_out), 32'd1);
    chk("reset/valid", 32'(bus.valid_out), 32'd0);
    chk("reset/result", bus.result_out, 32'd0);
    chk("reset/flags", {29'd0, bus.zero_out, bus.overflow_out, bus.div_by_zero_out}, 32'd0);
    rst = 1'b0;
    bus.valid_in = 1'b0;
    tick();
    chk("reset/no_accept", 32'(bus.ready_out), 32'd1);
    run("umul_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2'b00, 32'h00000001, 33, 1'b0, 1'b1, 1'b0);
    run("umulh_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2'b01, 32'hFFFFFFFE, 33, 1'b0, 1'b0, 1'b0);
    run("sdiv_m7_2", 32'hFFFFFFF9, 32'd2,        1'b1, 2'b10, 32'hFFFFFFFD, 33, 1'b0, 1'b0, 1'b0);
    run("srem_m7_2", 32'hFFFFFFF9, 32'd2,        1'b1, 2'b11, 32'hFFFFFFFF, 33, 1'b0, 1'b0, 1'b0);
    run("udiv_100_7", 32'd100,     32'd7,        1'b0, 2'b10, 32'h0000000E, 33, 1'b0, 1'b0, 1'b0);
    run("urem_100_7", 32'd100,     32'd7,        1'b0, 2'b11, 32'h00000002, 33, 1'b0, 1'b0, 1'b0);
    run("div_5_0",   32'd5,        32'd0,        1'b0, 2'b10, 32'hFFFFFFFF, 1,  1'b0, 1'b0, 1'b1);
    run("rem_5_0",   32'd5,        32'd0,        1'b1, 2'b11, 32'h00000005, 1,  1'b0, 1'b0, 1'b1);
    run("sdiv_min",  32'h80000000, 32'hFFFFFFFF, 1'b1, 2'b10, 32'h80000000, 1,  1'b0, 1'b1, 1'b0);
    run("srem_min",  32'h80000000, 32'hFFFFFFFF, 1'b1, 2'b11, 32'h00000000, 1,  1'b1, 1'b0, 1'b0);
    run("udiv_min",  32'h80000000, 32'hFFFFFFFF, 1'b0, 2'b10, 32'h00000000, 33, 1'b1, 1'b0, 1'b0);
    run("sdiv_7_m2", 32'd7,        32'hFFFFFFFE, 1'b1, 2'b10, 32'hFFFFFFFD, 33, 1'b0, 1'b0, 1'b0);
    run("srem_7_m2", 32'd7,        32'hFFFFFFFE, 1'b1, 2'b11, 32'h00000001, 33, 1'b0, 1'b0, 1'b0);
    run("sdiv_m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 2'b10, 32'h00000003, 33, 1'b0, 1'b0, 1'b0);
    run("smul_m3_5", 32'hFFFFFFFD, 32'd5,        1'b1, 2'b00, 32'hFFFFFFF1, 33, 1'b0, 1'b0, 1'b0);
    run("smulh_m3_5", 32'hFFFFFFFD, 32'd5,       1'b1, 2'b01, 32'hFFFFFFFF, 33, 1'b0, 1'b0, 1'b0);
    run("smul_ovf",  32'h00010000, 32'h00010000, 1'b1, 2'b00, 32'h00000000, 33, 1'b1, 1'b1, 1'b0);
    run("umulh_big", 32'h80000000, 32'h00000006, 1'b0, 2'b01, 32'h00000003, 33, 1'b0, 1'b0, 1'b0);
    bus.a_in = 32'd9;
    bus.b_in = 32'd9;
    bus.signed_operation_in = 1'b0;
    bus.operation_in = 2'b00;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midcalc/busy", 32'(bus.ready_out), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midcalc/ready", 32'(bus.ready_out), 32'd1);
    chk("midcalc/valid", 32'(bus.valid_out), 32'd0);
    chk("midcalc/result", bus.result_out, 32'd0);
    run("mul_3_4",   32'd3,        32'd4,        1'b0, 2'b00, 32'h0000000C, 33, 1'b0, 1'b0, 1'b0);
    issue(32'd7, 32'd6, 1'b0, 2'b00, lat);
    chk("hold/latency", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      bus.valid_in = 1'b1;
      bus.a_in = $urandom;
      bus.b_in = 32'd0;
      bus.operation_in = 2'b10;
      tick();
      chk("hold/result", bus.result_out, 32'h0000002A);
      chk("hold/state", {28'd0, bus.valid_out, bus.ready_out, bus.overflow_out, bus.div_by_zero_out}, 32'b1000);
    end
    bus.valid_in = 1'b0;
    consume("hold");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL be even and >= 8.
REQ-002 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 a_in  input  WIDTH  multiplicand or dividend.
REQ-005 b_in  input  WIDTH  multiplier or divisor.
REQ-006 signed_operation_in  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 operation_in  input  2  00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM.
REQ-008 valid_in  input  1  request valid.
REQ-009 ready_out  output  1  unit can accept a request.
REQ-010 result_out  output  WIDTH  result.
REQ-011 valid_out  output  1  result valid.
REQ-012 ready_in  input  1  consumer accepts the result.
REQ-013 zero_out  output  1  result_out == 0, qualified by valid_out.
REQ-014 overflow_out  output  1  overflow flag per REQ-024 and REQ-026.
REQ-015 div_by_zero_out  output  1  DIV/REM with b == 0.

Function
REQ-016 FSM states SHALL be IDLE, CALC and DONE.
REQ-017 ready_out SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on an edge where valid_in & ready_out; a_in, b_in, signed_operation_in and operation_in SHALL be latched at that edge and later input changes SHALL not affect the result.
REQ-019 Acceptance SHALL move IDLE -> CALC, except for the fast paths in REQ-025 and REQ-026, which move IDLE -> DONE.
REQ-020 CALC SHALL last exactly WIDTH cycles, processing one bit per cycle: shift-add for multiply, restoring division on operand magnitudes for divide; CALC -> DONE follows.
REQ-021 Latency: valid_out SHALL rise WIDTH+1 edges after acceptance on the normal path and 1 edge after acceptance on the fast paths.
REQ-022 In DONE, valid_out = 1 and result_out and all flags SHALL be held stable until ready_in = 1; on that edge the FSM SHALL go to IDLE, so ready_out = 1 in the next cycle.
- No new request is accepted in the same cycle the result is consumed.
REQ-023 MUL/MULH SHALL form the full 2*WIDTH product, signed or unsigned per the latched mode; MUL returns bits [WIDTH-1:0] and MULH returns bits [2*WIDTH-1:WIDTH].
REQ-024 Multiply overflow_out SHALL be 1 for MUL only:
- signed mode: high half is not the sign extension of the low half;
- unsigned mode: high half is nonzero;
- MULH: overflow_out = 0.
REQ-025 b == 0 with DIV/REM SHALL take the fast path:
- DIV returns all ones; REM returns the latched a;
- div_by_zero_out = 1, overflow_out = 0.
REQ-026 Signed DIV/REM with a = most-negative value and b = all ones SHALL take the fast path:
- DIV returns the most-negative value with overflow_out = 1;
- REM returns 0 with overflow_out = 0.
REQ-027 Signed divide SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend; quotient*b + remainder == a holds for every non-fast-path case.
REQ-028 div_by_zero_out SHALL be 0 for MUL/MULH; all flags SHALL be 0 whenever valid_out = 0.

Reset
REQ-029 rst_in = 1 at an edge SHALL force, in any state including mid-CALC:
- state IDLE, iteration counter 0;
- ready_out 1, valid_out 0, result_out 0;
- zero_out 0, overflow_out 0, div_by_zero_out 0.
REQ-030 A request presented while rst_in = 1 SHALL not be accepted; the first acceptance is possible on the edge after rst_in falls.

Verification (WIDTH = 32)
REQ-031 Unsigned MUL 0xFFFFFFFF * 0xFFFFFFFF -> result 0x00000001, overflow_out 1, valid_out on the 33rd edge after acceptance; MULH on the same operands -> 0xFFFFFFFE, overflow_out 0.
REQ-032 Signed DIV -7 / 2 -> 0xFFFFFFFD; signed REM -7 % 2 -> 0xFFFFFFFF; unsigned DIV 100 / 7 -> 0x0000000E, zero_out 0.
REQ-033 DIV 5 / 0 -> 0xFFFFFFFF, div_by_zero_out 1, valid_out 1 edge after acceptance; REM 5 % 0 -> 0x00000005.
REQ-034 Signed DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, overflow_out 1; REM on the same operands -> 0x00000000, zero_out 1.
REQ-035 rst_in pulsed in CALC cycle 10 -> ready_out 1 and valid_out 0 at the next edge; a following MUL 3 * 4 -> 0x0000000C after 33 edges.
REQ-036 ready_in held 0 for 5 cycles in DONE -> result_out and all flags stable, ready_out 0, and valid_in ignored; ready_in = 1 -> IDLE at the next edge.
